// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter / fetch-request controller.
package pc_pkg;

  localparam logic [1:0] SEL_BRANCH = 2'd0;
  localparam logic [1:0] SEL_JALR   = 2'd1;
  localparam logic [1:0] SEL_TRAP   = 2'd2;
  localparam logic [1:0] SEL_RET    = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pc_fetch_ctrl_target_sel.sv
// Redirect target selection: picks the target by redirect_sel, clears bit 0
// for JALR and flags targets that are not aligned to the fetch increment.
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int                      PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]     TRAP_VECTOR = PC_WIDTH'(32'h0000_0100),
  parameter int                      INC         = 4
) (
  input  logic [1:0]          sel,
  input  logic [PC_WIDTH-1:0] sum,
  input  logic [PC_WIDTH-1:0] epc,
  output logic [PC_WIDTH-1:0] target,
  output logic                misaligned
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INC - 1);

  always_comb begin
    target = sum;
    case (sel)
      SEL_BRANCH: target = sum;
      SEL_JALR:   target = {sum[PC_WIDTH-1:1], 1'b0};
      SEL_TRAP:   target = TRAP_VECTOR;
      SEL_RET:    target = epc;
      default:    target = sum;
    endcase
  end

  // With INC == 1 the mask is zero and nothing is ever misaligned.
  assign misaligned = |(target & ALIGN_MASK);

endmodule

// File: rtl/riscv_adder.sv
// Plain WIDTH-bit adder; the carry out is discarded so results wrap modulo 2^WIDTH.
module riscv_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and valid/ready instruction-fetch request controller with
// buffered redirects, stale-fetch kill and misaligned-target trapping.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(32'h0000_0000),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100),
  parameter int                  INC          = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [1:0]          redirect_sel,
  input  logic [PC_WIDTH-1:0] branch_pc,
  input  logic [PC_WIDTH-1:0] imm_ext,
  input  logic [PC_WIDTH-1:0] rs1_val,
  input  logic [PC_WIDTH-1:0] epc_in,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [PC_WIDTH-1:0] pc_plus_inc,
  output logic                fetch_kill,
  output logic                misalign_exc,
  output logic [PC_WIDTH-1:0] misalign_addr
);

  localparam logic [PC_WIDTH-1:0] INC_W = PC_WIDTH'(INC);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic                held_q, held_d;
  logic                mis_exc_q, mis_exc_d;
  logic [PC_WIDTH-1:0] mis_addr_q, mis_addr_d;

  logic [PC_WIDTH-1:0] base_s, tgt_sum_s, target_s, eff_target_s;
  logic                misaligned_s, hs_s, outstanding_s, kill_s;

  assign base_s = (redirect_sel == SEL_JALR) ? rs1_val : branch_pc;

  riscv_adder #(.WIDTH(PC_WIDTH)) u_inc_add (
    .a   (pc_q),
    .b   (INC_W),
    .sum (pc_plus_inc)
  );

  riscv_adder #(.WIDTH(PC_WIDTH)) u_tgt_add (
    .a   (base_s),
    .b   (imm_ext),
    .sum (tgt_sum_s)
  );

  pc_target_sel #(
    .PC_WIDTH    (PC_WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INC         (INC)
  ) u_target_sel (
    .sel        (redirect_sel),
    .sum        (tgt_sum_s),
    .epc        (epc_in),
    .target     (target_s),
    .misaligned (misaligned_s)
  );

  assign eff_target_s = misaligned_s ? TRAP_VECTOR : target_s;

  // A raised request stays up until accepted, even if decode starts stalling.
  assign imem_req_valid = held_q | ((state_q != ST_BOOT) & ~stall);
  assign hs_s           = imem_req_valid & imem_req_ready;
  assign outstanding_s  = imem_req_valid & ~imem_req_ready;

  assign imem_req_addr = pc_q;
  assign pc_out        = pc_q;
  assign fetch_kill    = kill_s & ~reset;
  assign misalign_exc  = mis_exc_q;
  assign misalign_addr = mis_addr_q;

  // Next-state, next-PC, pending-target and kill logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    held_d     = outstanding_s;
    kill_s     = 1'b0;
    mis_exc_d  = 1'b0;
    mis_addr_d = mis_addr_q;

    if (redirect_valid && misaligned_s) begin
      mis_exc_d  = 1'b1;
      mis_addr_d = target_s;
    end else begin
      mis_exc_d  = 1'b0;
      mis_addr_d = mis_addr_q;
    end

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (redirect_valid) pc_d = eff_target_s;
        else                pc_d = pc_q;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // An unaccepted request must keep its address, so park the target.
          if (outstanding_s) begin
            pend_d  = eff_target_s;
            state_d = ST_HOLD;
          end else begin
            pc_d   = eff_target_s;
            kill_s = hs_s;
          end
        end else if (hs_s) begin
          pc_d = pc_plus_inc;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_HOLD: begin
        if (redirect_valid && hs_s) begin
          pc_d    = eff_target_s;
          kill_s  = 1'b1;
          state_d = ST_RUN;
        end else if (redirect_valid) begin
          pend_d = eff_target_s;
        end else if (hs_s) begin
          pc_d    = pend_q;
          kill_s  = 1'b1;
          state_d = ST_RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      held_q     <= 1'b0;
      mis_exc_q  <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      held_q     <= held_d;
      mis_exc_q  <= mis_exc_d;
      mis_addr_q <= mis_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl with a short hand-written
// stall-while-held sequence at the end.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, imem_req_ready;
  logic [1:0]  redirect_sel;
  logic [31:0] branch_pc, imm_ext, rs1_val, epc_in;
  logic        imem_req_valid, fetch_kill, misalign_exc;
  logic [31:0] imem_req_addr, pc_out, pc_plus_inc, misalign_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .branch_pc      (branch_pc),
    .imm_ext        (imm_ext),
    .rs1_val        (rs1_val),
    .epc_in         (epc_in),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .pc_out         (pc_out),
    .pc_plus_inc    (pc_plus_inc),
    .fetch_kill     (fetch_kill),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] bpc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] epc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_kill;
    logic        e_mis;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst, input logic stl, input logic rv, input logic [1:0] sel,
                   input logic [31:0] bpc, input logic [31:0] rs1, input logic [31:0] imm,
                   input logic [31:0] epc, input logic rdy, input logic e_valid,
                   input logic [31:0] e_addr, input logic e_kill, input logic e_mis,
                   input logic [31:0] e_maddr);
    vec_t t;
    t.rst = rst; t.stl = stl; t.rv = rv; t.sel = sel; t.bpc = bpc; t.rs1 = rs1;
    t.imm = imm; t.epc = epc; t.rdy = rdy; t.e_valid = e_valid; t.e_addr = e_addr;
    t.e_kill = e_kill; t.e_mis = e_mis; t.e_maddr = e_maddr;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic e_valid, input logic [31:0] e_addr,
                         input logic e_kill, input logic e_mis, input logic [31:0] e_maddr);
    logic [31:0] e_inc;
    e_inc = e_addr + 32'd4;
    chk("valid", row, {31'd0, imem_req_valid}, {31'd0, e_valid});
    chk("addr", row, imem_req_addr, e_addr);
    chk("pc_out", row, pc_out, e_addr);
    chk("pc_plus_inc", row, pc_plus_inc, e_inc);
    chk("kill", row, {31'd0, fetch_kill}, {31'd0, e_kill});
    chk("misalign_exc", row, {31'd0, misalign_exc}, {31'd0, e_mis});
    chk("misalign_addr", row, misalign_addr, e_maddr);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_sel = 2'd0;
    branch_pc = 32'd0; imm_ext = 32'd0; rs1_val = 32'd0; epc_in = 32'd0;
    imem_req_ready = 1'b1;

    //   rst stl rv sel  bpc           rs1           imm           epc           rdy  valid addr          kill mis maddr
    v(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h4,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h8,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h8,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h8,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h8,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b0, 32'hC,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'hC,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd0, 32'hC,        32'h0,   32'h40, 32'h0,    1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h10,       1'b1, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h4C,       1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        32'h101, 32'h2,  32'h0,    1'b1, 1'b1, 32'h50,       1'b1, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h100,      1'b0, 1'b1, 32'h102);
    v(1'b0, 1'b1, 1'b1, 2'd0, 32'hFFFFFFF0, 32'h0,   32'hC,  32'h0,    1'b0, 1'b0, 32'h104,      1'b0, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        32'h0,   32'h0,  32'h2000, 1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h2000,     1'b0, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b1, 2'd2, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h2000,     1'b0, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        32'h300, 32'h10, 32'h0,    1'b0, 1'b1, 32'h2000,     1'b0, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h2000,     1'b1, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h310,      1'b0, 1'b0, 32'h102);
    v(1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        32'h0,   32'h22, 32'h0,    1'b0, 1'b1, 32'h310,      1'b0, 1'b0, 32'h102);
    v(1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b0, 1'b1, 32'h310,      1'b0, 1'b1, 32'h22);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b1, 2'd3, 32'h0,        32'h0,   32'h0,  32'h2002, 1'b1, 1'b1, 32'h4,        1'b1, 1'b0, 32'h0);
    v(1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        32'h0,   32'h0,  32'h0,    1'b1, 1'b1, 32'h100,      1'b0, 1'b1, 32'h2002);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset          = vecs[i].rst;
      stall          = vecs[i].stl;
      redirect_valid = vecs[i].rv;
      redirect_sel   = vecs[i].sel;
      branch_pc      = vecs[i].bpc;
      rs1_val        = vecs[i].rs1;
      imm_ext        = vecs[i].imm;
      epc_in         = vecs[i].epc;
      imem_req_ready = vecs[i].rdy;
      #1;
      chk_all(i, vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_kill, vecs[i].e_mis, vecs[i].e_maddr);
    end

    // Held request at 0x104 must survive a toggling stall until accepted.
    @(negedge clk);
    reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk_all(100, 1'b1, 32'h104, 1'b0, 1'b0, 32'h2002);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stall = k[0] ? 1'b0 : 1'b1;
      #1;
      chk_all(101 + k, 1'b1, 32'h104, 1'b0, 1'b0, 32'h2002);
    end
    @(negedge clk);
    stall = 1'b1; imem_req_ready = 1'b1;
    #1;
    chk_all(105, 1'b1, 32'h104, 1'b0, 1'b0, 32'h2002);
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk_all(106, 1'b1, 32'h108, 1'b0, 1'b0, 32'h2002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Next-generation parameterised program-counter and fetch-request controller for the RV32I core. It replaces the free-running PC register with a valid/ready instruction-memory request port and supports stalls and four redirect modes (branch, JALR, trap, return). A redirect that arrives while a request is held pending is buffered, and the fetch it supersedes is flagged as killed. Misaligned targets are detected and vectored to the trap handler.

Parameters:
PC_WIDTH, 32, width of the PC and of all address/data ports (at least 8)
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap redirect or misaligned target
INC, 4, sequential increment; must be a power of two

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  decode back-pressure; blocks a new request, never an outstanding one
redirect_valid  in  1  one-cycle redirect strobe from execute
redirect_sel  in  2  0 = branch (branch_pc+imm_ext), 1 = JALR ((rs1_val+imm_ext) & ~1), 2 = trap (TRAP_VECTOR), 3 = return (epc_in)
branch_pc  in  PC_WIDTH  PC of the redirecting instruction
imm_ext  in  PC_WIDTH  sign-extended immediate
rs1_val  in  PC_WIDTH  JALR base register value
epc_in  in  PC_WIDTH  return address
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  instruction memory accepts the request
imem_req_addr  out  PC_WIDTH  fetch address (equals pc_out)
pc_out  out  PC_WIDTH  current PC register
pc_plus_inc  out  PC_WIDTH  pc_out+INC, combinational
fetch_kill  out  1  the fetch accepted this cycle is stale; decode must drop its response
misalign_exc  out  1  one-cycle pulse: redirect target not INC-aligned
misalign_addr  out  PC_WIDTH  offending target, held until the next misalign event

Behaviour:
- Reset (sampled at the clk edge) overrides everything. Reset values: pc_out=RESET_VECTOR, state=BOOT, imem_req_valid=0, fetch_kill=0, misalign_exc=0, misalign_addr=0, pending target cleared, held flag cleared.
- States:
  - BOOT: one cycle with imem_req_valid=0, then go to RUN unconditionally.
  - RUN: normal fetch.
  - HOLD_REDIR: a redirect is pending behind an outstanding request.
- Request valid: imem_req_valid = held | (state!=BOOT & !stall). held is set on valid&!ready and cleared on handshake.
  - Once raised, valid and addr stay stable until ready, regardless of stall.
- Handshake (valid&ready) in RUN, no redirect: pc <= pc+INC, modulo 2^PC_WIDTH. 0xFFFF_FFFC wraps to 0.
- Redirect in RUN, no request held: pc <= target on the next edge; no kill. If a handshake happens in the same cycle, the redirect wins and fetch_kill=1 in that same cycle.
- Redirect in RUN while held&!ready: latch target into pend and go to HOLD_REDIR; addr unchanged.
- HOLD_REDIR:
  - A new redirect overwrites pend (newest wins).
  - On handshake: fetch_kill=1 in that cycle, pc <= pend, state <= RUN.
- Target computation: adds are full PC_WIDTH with carry discarded. JALR clears bit 0 before the alignment check.
- Misalignment: a target with target[log2(INC)-1:0] != 0 is misaligned.
  - misalign_exc pulses 1 on the cycle after detection.
  - misalign_addr <= target.
  - pc <= TRAP_VECTOR; trap and return targets are still checked.
- Priority: reset > redirect (sel as given) > pending > sequential.
- Mid-operation reset: an outstanding request is abandoned and the pending target discarded.
- Latency: redirect strobe to new imem_req_addr is 1 cycle when no request is held.

Decomposition:
- Shared package pc_pkg holds:
  - redirect_sel encodings: SEL_BRANCH, SEL_JALR, SEL_TRAP, SEL_RET.
  - FSM state enum: ST_BOOT, ST_RUN, ST_HOLD.
- Reuse riscv_adder twice: pc+INC and base+imm_ext, with the base muxed between branch_pc and rs1_val.
- One natural sub-module: pc_target_sel (target mux, bit-0 clear, alignment check), combinational.

Test Plan:
- Reset with ready=1 -> pc_out=0x0, valid=0 for one cycle, then addresses 0x0, 0x4, 0x8 on consecutive cycles.
- Hold ready=0 for 3 cycles at addr 0x8 while pulsing stall -> valid and addr stay 0x8 throughout; after ready, next addr is 0xC.
- At addr 0x10 with ready=0, redirect sel=0, branch_pc=0x0C, imm=0x40 -> addr holds 0x10; on handshake fetch_kill=1; next addr 0x4C.
- JALR with rs1=0x101, imm=0x2 -> target 0x102 (bit 0 cleared) -> misalign_exc pulse, misalign_addr=0x102, next addr 0x100.
- pc=0xFFFF_FFFC with a handshake -> next pc 0x0000_0000 with no flag; separately, sel=3 with epc=0x2000 -> addr 0x2000.
- Assert reset while in HOLD_REDIR -> next cycle pc=RESET_VECTOR, valid=0, fetch_kill=0, pending target discarded.
